prescaler_ctrl: RTL and testbench

Programmable tick scheduler built on one shared base divider. It produces per-channel one-cycle clock-enable strobes for the VGA animation logic, such as square movement and colour cycling, so that downstream logic stays on the single pixel clock instead of using divided clocks. Channel rates and enables are configured at run time over a valid/ready port. Reloads take effect only on base-tick boundaries, so no strobe is ever truncated or glitched.

---
 rtl/prescaler_pkg.sv | 19 +
 rtl/prescaler_ctrl_base.sv | 30 +++
 rtl/prescaler_ctrl.sv | 139 +++++++++++++
 tb/tb_prescaler_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prescaler_pkg.sv
// Shared types and constants for the prescaler tick scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package prescaler_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    localparam int BASE_DIV_DEF = 25000;
    localparam int DIV_DEF      = 99;

    // Channel index width; a single channel still needs a 1-bit index.
    function automatic int chw_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prescaler_ctrl_base.sv
// Free-running base divider; base_tick is high on the last count of each period.
// Latency: base_tick is combinational from the registered count.
// Backpressure: none; clr restarts the period from zero on the next edge.
module base_tick_gen #(
    parameter int BASE_DIV = 25000
) (
    input  logic clk_in,
    input  logic rst,
    input  logic clr,
    output logic base_tick
);

    localparam int CW = $clog2(BASE_DIV);

    logic [CW-1:0] cnt_q;

    assign base_tick = (cnt_q == CW'(BASE_DIV - 1));

    // Count 0..BASE_DIV-1 and wrap; clr forces the count back to zero.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr || base_tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/prescaler_ctrl.sv
// Per-channel one-cycle tick strobes derived from a shared base divider; optional readback via PRESCALER_CTRL_READBACK_EN.
// Latency: tick is registered, one cycle after the base tick that completes a channel period.
// Backpressure: cfg_ready drops after each accepted config until it is applied on the next base tick (or sync).
module prescaler_ctrl
    import prescaler_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int BASE_DIV = BASE_DIV_DEF,
    parameter int W        = 16,
    parameter int DEF_DIV  = DIV_DEF,
    localparam int CHW     = chw_of(NCH)
) (
    input  logic           clk_in,
    input  logic           rst,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [W-1:0]   cfg_div,
    input  logic           cfg_en,
    input  logic           sync,
`ifdef PRESCALER_CTRL_READBACK_EN
    input  logic [CHW-1:0] rd_ch,
    output logic [W-1:0]   rd_div,
    output logic           rd_en,
    output logic           rd_pend,
`endif
    output logic [NCH-1:0] tick
);

    state_t         state;
    logic [CHW-1:0] sh_ch;
    logic [W-1:0]   sh_div;
    logic           sh_en;

    logic [W-1:0]   div_q [NCH];
    logic [W-1:0]   cnt_q [NCH];
    logic [NCH-1:0] en_q;

    logic           base_tick;
    logic           apply;

    base_tick_gen #(
        .BASE_DIV (BASE_DIV)
    ) u_base (
        .clk_in    (clk_in),
        .rst       (rst),
        .clr       (sync),
        .base_tick (base_tick)
    );

    // A pending config lands on a base-tick boundary, or immediately on sync.
    assign apply = (state == PEND) && (base_tick || sync);

    // Config FSM: accept into the shadow register, hold off further requests until applied.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cfg_ready <= 1'b1;
            sh_ch     <= '0;
            sh_div    <= '0;
            sh_en     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        sh_ch     <= cfg_ch;
                        sh_div    <= cfg_div;
                        sh_en     <= cfg_en;
                        state     <= PEND;
                        cfg_ready <= 1'b0;
                    end
                end
                PEND: begin
                    if (base_tick || sync) begin
                        state     <= IDLE;
                        cfg_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cfg_ready <= 1'b1;
                end
            endcase
        end
    end

    // Channel counters: reload target is cleared and silenced; sync clears all; otherwise count base ticks.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            tick <= '0;
            en_q <= '1;
            for (int i = 0; i < NCH; i++) begin
                div_q[i] <= W'(DEF_DIV);
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (apply && (sh_ch == CHW'(i))) begin
                    div_q[i] <= sh_div;
                    en_q[i]  <= sh_en;
                    cnt_q[i] <= '0;
                    tick[i]  <= 1'b0;
                end else if (sync) begin
                    cnt_q[i] <= '0;
                    tick[i]  <= 1'b0;
                end else if (base_tick && en_q[i]) begin
                    if (cnt_q[i] == div_q[i]) begin
                        cnt_q[i] <= '0;
                        tick[i]  <= 1'b1;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                        tick[i]  <= 1'b0;
                    end
                end else begin
                    tick[i] <= 1'b0;
                end
            end
        end
    end

`ifdef PRESCALER_CTRL_READBACK_EN
    // Readback mux; an index with no matching channel reads as all zeros.
    always_comb begin
        rd_div  = '0;
        rd_en   = 1'b0;
        rd_pend = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (rd_ch == CHW'(i)) begin
                rd_div  = div_q[i];
                rd_en   = en_q[i];
                rd_pend = (state == PEND);
            end
        end
    end
`else
    // Readback port is not built in this configuration.
`endif

endmodule

// File: tb/tb_prescaler_ctrl.sv
module tb_prescaler_ctrl;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       sync = 1'b0;

    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [1:0] cfg_ch = '0;
    logic [7:0] cfg_div = '0;
    logic       cfg_en = 1'b0;
    logic [3:0] tick;

    logic       cfg_valid3 = 1'b0;
    logic       cfg_ready3;
    logic [1:0] cfg_ch3 = '0;
    logic [7:0] cfg_div3 = '0;
    logic       cfg_en3 = 1'b0;
    logic [2:0] tick3;

`ifdef PRESCALER_CTRL_READBACK_EN
    logic [1:0] rd_ch = '0;
    logic [7:0] rd_div;
    logic       rd_en;
    logic       rd_pend;
    logic [1:0] rd_ch3 = '0;
    logic [7:0] rd_div3;
    logic       rd_en3;
    logic       rd_pend3;
`endif

    int checks = 0;
    int errors = 0;
    int cur = 0;

    always #5 clk_in = ~clk_in;

    prescaler_ctrl #(.NCH(4), .BASE_DIV(4), .W(8), .DEF_DIV(3)) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_en    (cfg_en),
        .sync      (sync),
`ifdef PRESCALER_CTRL_READBACK_EN
        .rd_ch     (rd_ch),
        .rd_div    (rd_div),
        .rd_en     (rd_en),
        .rd_pend   (rd_pend),
`endif
        .tick      (tick)
    );

    prescaler_ctrl #(.NCH(3), .BASE_DIV(4), .W(8), .DEF_DIV(3)) dut3 (
        .clk_in    (clk_in),
        .rst       (rst),
        .cfg_valid (cfg_valid3),
        .cfg_ready (cfg_ready3),
        .cfg_ch    (cfg_ch3),
        .cfg_div   (cfg_div3),
        .cfg_en    (cfg_en3),
        .sync      (sync),
`ifdef PRESCALER_CTRL_READBACK_EN
        .rd_ch     (rd_ch3),
        .rd_div    (rd_div3),
        .rd_en     (rd_en3),
        .rd_pend   (rd_pend3),
`endif
        .tick      (tick3)
    );

    // Advance to the sampling point of cycle n (just before rising edge n).
    task automatic goto(input int n);
        while (cur < n) begin
            @(negedge clk_in);
            cur++;
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        sync       = 1'b0;
        cfg_valid  = 1'b0;
        cfg_valid3 = 1'b0;
        repeat (2) @(negedge clk_in);
        rst = 1'b0;
        cur = 0;
    endtask

    task automatic test_reset();
        logic [3:0] exp;
        rst = 1'b1;
        repeat (2) @(negedge clk_in);
        checks++;
        if (tick !== 4'h0 || cfg_ready !== 1'b1 || tick3 !== 3'h0) begin
            errors++;
            $display("FAIL reset_state tick=%h ready=%b tick3=%h required 0/1/0", tick, cfg_ready, tick3);
        end
        rst = 1'b0;
        cur = 0;
        for (int n = 0; n <= 40; n++) begin
            goto(n);
            exp = (n >= 16 && n % 16 == 0) ? 4'hF : 4'h0;
            checks++;
            if (tick !== exp) begin
                errors++;
                $display("FAIL default_sched cycle %0d tick=%h required %h", n, tick, exp);
            end
            checks++;
            if (dut.u_base.base_tick !== (n % 4 == 3)) begin
                errors++;
                $display("FAIL base_tick cycle %0d got %b required %b", n, dut.u_base.base_tick, (n % 4 == 3));
            end
        end
    endtask

    task automatic test_cfg_div0();
        logic [3:0] exp;
        logic       exp_rdy;
        do_reset();
        goto(1);
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd0; cfg_en = 1'b1;
        for (int n = 2; n <= 33; n++) begin
            goto(n);
            cfg_valid = 1'b0;
            exp = (n >= 16 && n % 16 == 0) ? 4'b1011 : 4'b0000;
            if (n >= 8 && n % 4 == 0) exp[2] = 1'b1;
            exp_rdy = !(n == 2 || n == 3);
            checks++;
            if (tick !== exp || cfg_ready !== exp_rdy) begin
                errors++;
                $display("FAIL cfg_div0 cycle %0d tick=%h ready=%b required %h/%b", n, tick, cfg_ready, exp, exp_rdy);
            end
        end
    endtask

    task automatic test_disable_reenable();
        logic [3:0] exp;
        do_reset();
        goto(1);
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd3; cfg_en = 1'b0;
        for (int n = 2; n <= 36; n++) begin
            goto(n);
            cfg_valid = 1'b0;
            exp = (n >= 16 && n % 16 == 0) ? 4'b1101 : 4'b0000;
            checks++;
            if (tick !== exp) begin
                errors++;
                $display("FAIL disabled cycle %0d tick=%h required %h", n, tick, exp);
            end
        end
        goto(37);
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd1; cfg_en = 1'b1;
        for (int n = 38; n <= 66; n++) begin
            goto(n);
            cfg_valid = 1'b0;
            exp = (n % 16 == 0) ? 4'b1101 : 4'b0000;
            if (n >= 48 && n % 8 == 0) exp[1] = 1'b1;
            checks++;
            if (tick !== exp) begin
                errors++;
                $display("FAIL reenable cycle %0d tick=%h required %h", n, tick, exp);
            end
        end
    endtask

    task automatic test_sync();
        logic [3:0] exp;
        do_reset();
        goto(11);
        sync = 1'b1;
        goto(12);
        sync = 1'b0;
        checks++;
        if (dut.u_base.cnt_q !== 2'd0) begin
            errors++;
            $display("FAIL sync_base cnt=%0d required 0", dut.u_base.cnt_q);
        end
        for (int n = 12; n <= 45; n++) begin
            goto(n);
            exp = (n >= 28 && (n - 28) % 16 == 0) ? 4'hF : 4'h0;
            checks++;
            if (tick !== exp) begin
                errors++;
                $display("FAIL sync_sched cycle %0d tick=%h required %h", n, tick, exp);
            end
        end
    endtask

    task automatic test_sync_pend();
        logic [3:0] exp;
        do_reset();
        goto(1);
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd0; cfg_en = 1'b1;
        goto(2);
        cfg_valid = 1'b0;
        sync = 1'b1;
        for (int n = 3; n <= 24; n++) begin
            goto(n);
            sync = 1'b0;
            exp = (n == 19) ? 4'b1110 : 4'b0000;
            if (n >= 7 && (n - 7) % 4 == 0) exp[0] = 1'b1;
            checks++;
            if (tick !== exp || cfg_ready !== 1'b1) begin
                errors++;
                $display("FAIL sync_pend cycle %0d tick=%h ready=%b required %h/1", n, tick, cfg_ready, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp;
        logic       exp_rdy;
        do_reset();
        goto(1);
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd1; cfg_en = 1'b1;
        for (int n = 2; n <= 33; n++) begin
            goto(n);
            if (n == 2) begin
                cfg_ch = 2'd2; cfg_div = 8'd0; cfg_en = 1'b1;
            end
            if (n == 5) cfg_valid = 1'b0;
            exp = (n >= 16 && n % 16 == 0) ? 4'b0011 : 4'b0000;
            if (n >= 12 && (n - 12) % 8 == 0) exp[3] = 1'b1;
            if (n >= 12 && n % 4 == 0) exp[2] = 1'b1;
            exp_rdy = !(n == 2 || n == 3 || (n >= 5 && n <= 7));
            checks++;
            if (tick !== exp || cfg_ready !== exp_rdy) begin
                errors++;
                $display("FAIL back_to_back cycle %0d tick=%h ready=%b required %h/%b", n, tick, cfg_ready, exp, exp_rdy);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [2:0] exp;
        logic       exp_rdy;
        do_reset();
        goto(1);
        cfg_valid3 = 1'b1; cfg_ch3 = 2'd3; cfg_div3 = 8'd0; cfg_en3 = 1'b0;
        for (int n = 2; n <= 33; n++) begin
            goto(n);
            cfg_valid3 = 1'b0;
            exp = (n >= 16 && n % 16 == 0) ? 3'b111 : 3'b000;
            exp_rdy = !(n == 2 || n == 3);
            checks++;
            if (tick3 !== exp || cfg_ready3 !== exp_rdy) begin
                errors++;
                $display("FAIL out_of_range cycle %0d tick=%h ready=%b required %h/%b", n, tick3, cfg_ready3, exp, exp_rdy);
            end
        end
    endtask

    task automatic test_reset_pend();
        logic [3:0] exp;
        do_reset();
        goto(15);
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd0; cfg_en = 1'b1;
        goto(16);
        cfg_valid = 1'b0;
        checks++;
        if (tick !== 4'hF || cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset tick=%h ready=%b required f/0", tick, cfg_ready);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (tick !== 4'h0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset tick=%h ready=%b required 0/1", tick, cfg_ready);
        end
        @(negedge clk_in);
        rst = 1'b0;
        cur = 0;
        for (int n = 0; n <= 33; n++) begin
            goto(n);
            exp = (n >= 16 && n % 16 == 0) ? 4'hF : 4'h0;
            checks++;
            if (tick !== exp) begin
                errors++;
                $display("FAIL reset_pend cycle %0d tick=%h required %h", n, tick, exp);
            end
        end
    endtask

`ifdef PRESCALER_CTRL_READBACK_EN
    task automatic test_readback();
        do_reset();
        rd_ch  = 2'd1;
        rd_ch3 = 2'd3;
        goto(1);
        checks++;
        if (rd_div !== 8'd3 || rd_en !== 1'b1 || rd_pend !== 1'b0) begin
            errors++;
            $display("FAIL readback div=%0d en=%b pend=%b required 3/1/0", rd_div, rd_en, rd_pend);
        end
        checks++;
        if (rd_div3 !== 8'd0 || rd_en3 !== 1'b0 || rd_pend3 !== 1'b0) begin
            errors++;
            $display("FAIL readback_oor div=%0d en=%b pend=%b required 0/0/0", rd_div3, rd_en3, rd_pend3);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_cfg_div0();
        test_disable_reenable();
        test_sync();
        test_sync_pend();
        test_back_to_back();
        test_out_of_range();
        test_reset_pend();
`ifdef PRESCALER_CTRL_READBACK_EN
        test_readback();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
